// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, 3-sample majority voting,
// LSB-first deserialisation, parity/stop checking and one-cycle result pulses.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8,
  localparam int EW        = $clog2(PRESCALE)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [EW-1:0]         Edge_Counts,
  input  logic [3:0]            Bit_Counts,
  output logic                  Counter_Enable,
  output logic                  Parity_Enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] EDGE_DEC  = EW'(PRESCALE / 2 + 2);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [3:0]    BC_DLAST  = 4'(DATA_WIDTH);
  localparam logic [3:0]    BC_PAR    = 4'(DATA_WIDTH + 1);

  state_t                  state_q, state_d;
  logic [2:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    rpar_q, rpar_d;
  logic                    perr_q, perr_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    data_valid_q, data_valid_d;
  logic                    parity_error_q, parity_error_d;
  logic                    stop_error_q, stop_error_d;
  logic                    decide, wrap, bit_v, mismatch;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_comb begin
    state_d        = state_q;
    samp_d         = samp_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    rpar_d         = rpar_q;
    perr_d         = perr_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    mismatch       = 1'b0;
    decide         = (Edge_Counts == EDGE_DEC);
    wrap           = (Edge_Counts == EDGE_LAST);
    bit_v          = maj3(samp_q);

    if (state_q != IDLE) begin
      if (Edge_Counts == EDGE_S0) samp_d[0] = RX_IN;
      if (Edge_Counts == EDGE_S1) samp_d[1] = RX_IN;
      if (Edge_Counts == EDGE_S2) samp_d[2] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          rpar_d    = 1'b0;
          perr_d    = 1'b0;
        end
      end
      START: begin
        if (decide && bit_v) state_d = IDLE;
        else if (wrap) begin
          if (Bit_Counts != 4'd0) mismatch = 1'b1;
          else                    state_d  = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
          rpar_d  = rpar_q ^ bit_v;
        end
        if (wrap) begin
          if (Bit_Counts == 4'd0 || Bit_Counts > BC_DLAST) mismatch = 1'b1;
          else if (Bit_Counts == BC_DLAST) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) perr_d = bit_v ^ rpar_q ^ par_typ_q;
        if (wrap) begin
          if (Bit_Counts != BC_PAR) mismatch = 1'b1;
          else                      state_d  = STOP;
        end
      end
      STOP: begin
        // Frame ends at the stop bit's decide edge, leaving its tail free for the next start bit.
        if (decide) begin
          state_d = IDLE;
          if (perr_q)      parity_error_d = 1'b1;
          else if (!bit_v) stop_error_d   = 1'b1;
          else begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end else if (wrap) begin
          mismatch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mismatch) begin
      state_d      = IDLE;
      stop_error_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      samp_q         <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      rpar_q         <= 1'b0;
      perr_q         <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      samp_q         <= samp_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      rpar_q         <= rpar_d;
      perr_q         <= perr_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign Counter_Enable = (state_q != IDLE);
  assign Parity_Enable  = par_en_q;
  assign P_DATA         = p_data_q;
  assign Data_Valid     = data_valid_q;
  assign Parity_Error   = parity_error_q;
  assign Stop_Error     = stop_error_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the RX edge/bit counter, drives serial frames
// and checks result pulses against directed vectors and a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  localparam int P  = 8;
  localparam int DW = 8;
  localparam int M  = P / 2;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP;
  logic [2:0] Edge_Counts;
  logic [3:0] Bit_Counts;
  logic       Counter_Enable, Parity_Enable, Data_Valid, Parity_Error, Stop_Error;
  logic [7:0] P_DATA;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Edge_Counts(Edge_Counts), .Bit_Counts(Bit_Counts),
    .Counter_Enable(Counter_Enable), .Parity_Enable(Parity_Enable), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
  );

  always #5 CLK = ~CLK;

  // RX edge/bit counter: holds 0/0 while disabled, edge wraps 7 -> 0 and bumps the bit index.
  always @(posedge CLK) begin
    if (!Counter_Enable) begin
      Edge_Counts <= 3'd0;
      Bit_Counts  <= 4'd0;
    end else if (Edge_Counts == 3'd7) begin
      Edge_Counts <= 3'd0;
      Bit_Counts  <= Bit_Counts + 4'd1;
    end else begin
      Edge_Counts <= Edge_Counts + 3'd1;
    end
  end

  int compared = 0;
  int mismatched = 0;
  int n_dv, n_pe, n_se, n_ce;
  logic [7:0] words[$];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_dv = 0; n_pe = 0; n_se = 0; n_ce = 0;
    words.delete();
  endtask

  always @(negedge CLK) begin
    if (Counter_Enable === 1'b1) n_ce++;
    if (Data_Valid === 1'b1) begin
      n_dv++;
      words.push_back(P_DATA);
    end
    if (Parity_Error === 1'b1) n_pe++;
    if (Stop_Error === 1'b1) n_se++;
    if ((Data_Valid | Parity_Error | Stop_Error) === 1'b1)
      check("pulse_exclusive", int'(Data_Valid) + int'(Parity_Error) + int'(Stop_Error), 1);
  end

  // Called at a negedge; each bit is held for P clocks, stop bit included.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt, input bit pbit,
                            input bit sbit, input bit cfg_flip);
    RX_IN = 1'b0; PAR_EN = pe; PAR_TYP = pt;
    repeat (P) @(negedge CLK);
    for (int i = 0; i < DW; i++) begin
      RX_IN = d[i];
      if (i == 1) begin
        check("parity_enable_latched", int'(Parity_Enable), int'(pe));
        if (cfg_flip) begin PAR_EN = ~pe; PAR_TYP = ~pt; end
      end
      repeat (P) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (P) @(negedge CLK);
    end
    RX_IN = sbit;
    repeat (P) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit pe, pt, pbit, sbit;
    bit exp_dv, exp_perr, exp_serr;
    logic [7:0] exp_pdata;
    int exp_ce;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_pdata;

    // Counter_Enable spans start + data (+ parity) bits, plus the stop bit up to its decide edge.
    vecs[0] = '{8'h55, 0, 0, 0, 1, 1, 0, 0, 8'h55, 79};
    vecs[1] = '{8'hA3, 1, 0, 0, 1, 1, 0, 0, 8'hA3, 87};
    vecs[2] = '{8'hA3, 1, 1, 0, 1, 0, 1, 0, 8'hA3, 87};
    vecs[3] = '{8'h0F, 0, 0, 0, 0, 0, 0, 1, 8'hA3, 79};
    vecs[4] = '{8'hFF, 1, 1, 1, 1, 1, 0, 0, 8'hFF, 87};
    vecs[5] = '{8'h00, 1, 0, 1, 1, 0, 1, 0, 8'hFF, 87};
    vecs[6] = '{8'h81, 1, 0, 0, 0, 0, 0, 1, 8'hFF, 87};
    vecs[7] = '{8'h3C, 0, 0, 0, 1, 1, 0, 0, 8'h3C, 79};

    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_counter_enable", int'(Counter_Enable), 0);
    check("reset_parity_enable", int'(Parity_Enable), 0);
    check("reset_p_data", int'(P_DATA), 0);
    check("reset_data_valid", int'(Data_Valid), 0);
    check("reset_parity_error", int'(Parity_Error), 0);
    check("reset_stop_error", int'(Stop_Error), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit, 1'b0);
      repeat (3) @(negedge CLK);
      check($sformatf("vec%0d_data_valid", i), n_dv, int'(vecs[i].exp_dv));
      check($sformatf("vec%0d_parity_error", i), n_pe, int'(vecs[i].exp_perr));
      check($sformatf("vec%0d_stop_error", i), n_se, int'(vecs[i].exp_serr));
      check($sformatf("vec%0d_p_data", i), int'(P_DATA), int'(vecs[i].exp_pdata));
      check($sformatf("vec%0d_enable_cycles", i), n_ce, vecs[i].exp_ce);
    end

    // Start-bit glitch: three low clocks, majority at the decide edge reads 1.
    clear_mon();
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (12) @(negedge CLK);
    check("glitch_enable_cycles", n_ce, M + 3);
    check("glitch_counter_enable", int'(Counter_Enable), 0);
    check("glitch_pulses", n_dv + n_pe + n_se, 0);
    check("glitch_p_data", int'(P_DATA), 8'h3C);

    // Back-to-back frames with a single stop bit between them.
    clear_mon();
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    check("b2b_valid_count", n_dv, 2);
    check("b2b_word0", (words.size() > 0) ? int'(words[0]) : -1, 8'h12);
    check("b2b_word1", (words.size() > 1) ? int'(words[1]) : -1, 8'h34);
    check("b2b_errors", n_pe + n_se, 0);

    // Reset in the middle of the data bits of 0x77.
    clear_mon();
    RX_IN = 1'b0; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    repeat (P) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX_IN = (i == 2) ? 1'b1 : 1'b1;
      repeat (P) @(negedge CLK);
    end
    check("midframe_counter_enable", int'(Counter_Enable), 1);
    check("midframe_parity_enable", int'(Parity_Enable), 1);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_counter_enable", int'(Counter_Enable), 0);
    check("abort_parity_enable", int'(Parity_Enable), 0);
    check("abort_p_data", int'(P_DATA), 0);
    check("abort_pulse_levels", int'(Data_Valid) + int'(Parity_Error) + int'(Stop_Error), 0);
    RST = 1'b1; RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort_no_pulses", n_dv + n_pe + n_se, 0);
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    check("after_abort_valid", n_dv, 1);
    check("after_abort_p_data", int'(P_DATA), 8'h3C);

    // Random frames against a frame-level reference model.
    exp_pdata = 8'h3C;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit pe, pt, pbit, sbit, flip, perr;
      int ones;
      d    = 8'($urandom);
      pe   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      flip = 1'($urandom_range(0, 1));
      sbit = ($urandom_range(0, 7) != 0);
      // Correct parity bit gives an even (PAR_TYP=0) or odd (PAR_TYP=1) total count of ones.
      pbit = 1'(($countones(d) + int'(pt)) % 2);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      ones = $countones(d) + int'(pbit);
      perr = pe && ((ones % 2) != int'(pt));
      clear_mon();
      send_frame(d, pe, pt, pbit, sbit, flip);
      repeat (3) @(negedge CLK);
      if (!perr && sbit) exp_pdata = d;
      check($sformatf("rnd%0d_data_valid", n), n_dv, int'(!perr && sbit));
      check($sformatf("rnd%0d_parity_error", n), n_pe, int'(perr));
      check($sformatf("rnd%0d_stop_error", n), n_se, int'(!perr && !sbit));
      check($sformatf("rnd%0d_p_data", n), int'(P_DATA), int'(exp_pdata));
      check($sformatf("rnd%0d_enable_cycles", n), n_ce, (1 + DW + int'(pe)) * P + M + 3);
      repeat ($urandom_range(0, 4)) @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
